disp_scheduler: RTL and testbench
=================================

// Module: disp_scheduler
// PURPOSE
//  Time-shares the single 8-digit 7-segment display between N_SRC requesters.
//  Each requester presents a 32-bit hex value and a level request.
//  Grants are round-robin, and each grant is held for a minimum on-screen time.
//  out_num feeds the in_num input of the display driver. The scheduler sits
//  between application blocks (counters, ALU results, etc.) and the display driver.
// PARAMETERS
//  N_SRC       4       number of requesters (2..8)
//  TICK_DIV    100000  clk cycles per hold tick (>=2)
//  HOLD_TICKS  100     ticks each grant is held before re-arbitration (>=1)
// PORTS
//  clk        in   1         system clock
//  reset      in   1         synchronous, active-low reset
//  req        in   N_SRC     level request per source
//  src_num    in   32*N_SRC  source i value at [32*i+31:32*i]
//  grant      out  N_SRC     one-hot owner of the display; all-zero when idle
//  out_num    out  32        value to the display driver in_num
//  out_valid  out  1         1 while a source owns the display
// BEHAVIOUR
//  Reset (reset==0 at a posedge):
//   - next edge: grant=0, out_num=0, out_valid=0, state=IDLE.
//   - rr pointer set to N_SRC-1, so source 0 wins first.
//   - Tick prescaler and hold counter are cleared.
//   - Reset mid-hold aborts the grant immediately.
//  States: IDLE, SHOW.
//  IDLE:
//   - If any req bit is 1, the edge that samples it loads grant with the first
//     requester after the rr pointer (cyclic search). That edge also sets
//     out_valid=1, loads out_num=src_num[owner], clears the prescaler,
//     loads hold=HOLD_TICKS-1, and moves to SHOW.
//   - Latency is 1 cycle from req to grant.
//  SHOW:
//   - Every edge with req[owner]==1 updates out_num from src_num[owner]
//     (1-cycle tracking). With req[owner]==0, out_num freezes at its last value.
//     The grant is still held (minimum display time).
//   - The prescaler pulses tick once every TICK_DIV cycles.
//     On tick with hold!=0: hold decrements.
//   - Expiry = tick with hold==0, i.e. exactly HOLD_TICKS*TICK_DIV cycles after
//     the grant edge. At expiry:
//     - Another source requesting: grant moves, on the same edge, to the next
//       requester after the current owner. rr = old owner, out_num loads the new
//       value, prescaler cleared, hold reloaded, stays in SHOW.
//     - Only the owner requesting: grant unchanged, hold reloaded, no gap.
//     - No requests: state=IDLE, grant=0, out_valid=0, out_num holds its last value.
//  Simultaneous events:
//   - A req rising on the same edge as expiry takes part in that arbitration.
//   - A req rising mid-hold waits for expiry. There is no pre-emption.
//  Width rules:
//   - Prescaler is $clog2(TICK_DIV) bits; hold counter is $clog2(HOLD_TICKS+1) bits.
//   - Both wrap only via explicit reload, never by overflow.
//  grant is always one-hot or zero; never more than one bit set.
// STRUCTURE
//  Package disp_pkg:
//   - typedef enum logic {IDLE, SHOW} disp_state_t
//   - localparam DIGIT_W=4, NUM_W=32
//  Sub-module tick_gen #(TICK_DIV): ports clk, reset, clear, tick.
//   - tick is a 1-cycle pulse; clear restarts the count.
//  Round-robin pick is a combinational function in this module.
// TESTING (bench uses N_SRC=4, TICK_DIV=4, HOLD_TICKS=3 -> 12-cycle hold)
//  1. reset=0 for 2 cycles, req=0000 -> grant=0000, out_valid=0, out_num=0.
//  2. req=0001, src0=0x12345678 -> 1 edge later grant=0001, out_num=0x12345678.
//     Held indefinitely with no glitch at 12-cycle reloads.
//     src0 changed to 0xCAFE0001 -> out_num follows 1 cycle later.
//  3. req=0101 from IDLE -> grant 0001 for 12 cycles, then 0100 for 12, then 0001.
//  4. req=0011, src0 drops req 2 cycles after grant -> grant 0001 held to cycle 12,
//     out_num frozen at last src0 value, then grant=0010.
//  5. All req drop during SHOW -> at expiry grant=0000, out_valid=0, out_num unchanged.
//  6. reset=0 at cycle 5 of a hold -> next edge all outputs 0.
//     After reset=1 with req=1111 -> grant=0001 first, then 0010, 0100, 1000.

Source files
------------

// File: rtl/disp_pkg.sv
// disp_pkg: shared types and widths for the display scheduler.
package disp_pkg;
    typedef enum logic {IDLE, SHOW} disp_state_t;
    localparam int DIGIT_W = 4;
    localparam int NUM_W = 8 * DIGIT_W;
endpackage

// File: rtl/disp_scheduler_if.sv
// disp_scheduler_if: requester-side bundle of requests, values and the granted display output.
interface disp_scheduler_if #(parameter int N_SRC = 4);
    import disp_pkg::*;
    logic [N_SRC-1:0] req;
    logic [NUM_W*N_SRC-1:0] src_num;
    logic [N_SRC-1:0] grant;
    logic [NUM_W-1:0] out_num;
    logic out_valid;
    modport master (output req, src_num, input grant, out_num, out_valid);
    modport slave (input req, src_num, output grant, out_num, out_valid);
endinterface

// File: rtl/disp_scheduler_tick_gen.sv
// tick_gen: one-cycle tick every TICK_DIV cycles; clear restarts the count.
module tick_gen #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int CW = $clog2(TICK_DIV);
    logic [CW-1:0] cnt_q, cnt_d;
    assign tick = cnt_q == CW'(TICK_DIV - 1);
    always_comb cnt_d = (clear || tick) ? '0 : cnt_q + CW'(1);
    always_ff @(posedge clk) begin
        if (!reset) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/disp_scheduler.sv
// disp_scheduler: round-robin time-sharing of one 8-digit display between N_SRC requesters,
// each grant held for HOLD_TICKS ticks of TICK_DIV cycles before re-arbitration.
module disp_scheduler
    import disp_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int TICK_DIV = 100000,
    parameter int HOLD_TICKS = 100
) (
    input logic clk,
    input logic reset,
    disp_scheduler_if.slave bus
);
    localparam int IW = $clog2(N_SRC);
    localparam int HW = $clog2(HOLD_TICKS + 1);

    disp_state_t state_q, state_d;
    logic [N_SRC-1:0] grant_q, grant_d;
    logic [IW-1:0] owner_q, owner_d, rr_q, rr_d, pick;
    logic [HW-1:0] hold_q, hold_d;
    logic [NUM_W-1:0] out_num_q, out_num_d;
    logic out_valid_q, out_valid_d;
    logic clear, tick;

    // First requester strictly after p, wrapping round to p itself last.
    function automatic logic [IW-1:0] rr_pick(input logic [N_SRC-1:0] r, input logic [IW-1:0] p);
        rr_pick = p;
        for (int k = N_SRC; k >= 1; k--)
            if (r[(int'(p) + k) % N_SRC]) rr_pick = IW'((int'(p) + k) % N_SRC);
    endfunction

    function automatic logic [NUM_W-1:0] src_of(input logic [IW-1:0] i);
        return bus.src_num[int'(i)*NUM_W +: NUM_W];
    endfunction

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk(clk), .reset(reset), .clear(clear), .tick(tick)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        rr_d = rr_q;
        hold_d = hold_q;
        out_num_d = out_num_q;
        out_valid_d = out_valid_q;
        clear = 1'b0;
        pick = rr_pick(bus.req, state_q == IDLE ? rr_q : owner_q);
        if (state_q == IDLE) begin
            clear = 1'b1;
            if (|bus.req) begin
                state_d = SHOW;
                owner_d = pick;
                grant_d = N_SRC'(1) << pick;
                out_valid_d = 1'b1;
                out_num_d = src_of(pick);
                hold_d = HW'(HOLD_TICKS - 1);
            end
        end else begin
            if (bus.req[owner_q]) out_num_d = src_of(owner_q);
            if (tick && hold_q != '0) hold_d = hold_q - HW'(1);
            // Expiry: re-arbitrate among everyone still requesting, owner searched last.
            if (tick && hold_q == '0) begin
                clear = 1'b1;
                if (|bus.req) begin
                    owner_d = pick;
                    grant_d = N_SRC'(1) << pick;
                    out_num_d = src_of(pick);
                    hold_d = HW'(HOLD_TICKS - 1);
                    rr_d = pick != owner_q ? owner_q : rr_q;
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                    out_valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            rr_q <= IW'(N_SRC - 1);
            hold_q <= '0;
            out_num_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            rr_q <= rr_d;
            hold_q <= hold_d;
            out_num_q <= out_num_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.out_num = out_num_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_disp_scheduler.sv
// tb_disp_scheduler: directed scenarios plus random traffic against a cycle-age reference model.
module tb_disp_scheduler;
    localparam int N = 4;
    localparam int TD = 4;
    localparam int HT = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [31:0] src [N];
    int n_checks = 0;
    int n_fail = 0;
    int m_owner = -1;
    int m_rr = N - 1;
    int m_age = 0;
    logic [31:0] m_num = '0;

    disp_scheduler_if #(.N_SRC(N)) bus ();
    disp_scheduler #(.N_SRC(N), .TICK_DIV(TD), .HOLD_TICKS(HT)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;
    always_comb for (int i = 0; i < N; i++) bus.src_num[32*i +: 32] = src[i];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic int next_after(input logic [N-1:0] r, input int p);
        for (int k = 1; k <= N; k++) if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // Owner keeps the display for TD*HT edges after its grant edge, then re-arbitration.
    task automatic model_edge();
        int w;
        if (!reset) begin
            m_owner = -1; m_rr = N - 1; m_age = 0; m_num = '0;
        end else if (m_owner < 0) begin
            w = next_after(bus.req, m_rr);
            if (w >= 0) begin m_owner = w; m_age = 0; m_num = src[w]; end
        end else begin
            m_age++;
            if (bus.req[m_owner]) m_num = src[m_owner];
            if (m_age == TD * HT) begin
                w = next_after(bus.req, m_owner);
                if (w < 0) m_owner = -1;
                else begin
                    if (w != m_owner) m_rr = m_owner;
                    m_owner = w; m_age = 0; m_num = src[w];
                end
            end
        end
    endtask

    task automatic step(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            model_edge();
            #1;
            check("grant", 32'(bus.grant), m_owner < 0 ? 32'd0 : 32'd1 << m_owner);
            check("out_valid", 32'(bus.out_valid), 32'(m_owner >= 0));
            check("out_num", bus.out_num, m_num);
            @(negedge clk);
        end
    endtask

    initial begin
        src[0] = 32'h12345678; src[1] = 32'h11110001; src[2] = 32'h22220002; src[3] = 32'h33330003;
        bus.req = '0;
        @(negedge clk);
        step(2);
        reset = 1'b1;
        step(2);
        bus.req = 4'b0001;
        step(30);
        src[0] = 32'hCAFE0001;
        step(3);
        bus.req = 4'b0000;
        step(14);
        bus.req = 4'b0101;
        step(40);
        bus.req = 4'b0000;
        step(14);
        bus.req = 4'b0011;
        step(3);
        bus.req = 4'b0010;
        src[0] = 32'hDEAD0000;
        step(14);
        bus.req = 4'b0000;
        step(14);
        bus.req = 4'b1111;
        step(17);
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        step(55);
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(7) == 0) bus.req = 4'($urandom);
            for (int i = 0; i < N; i++) if ($urandom_range(3) == 0) src[i] = $urandom;
            reset = $urandom_range(249) != 0;
            step(1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
